// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store engine: access codes, opcodes,
// FSM states and small decode helpers.
package mem_access_unit_pkg;

    localparam int DEF_ADDR_W = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [2:0] access_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores have no unsigned variants, so any funct3[2] store is reserved.
    function automatic logic f3_reserved(input logic [2:0] f3, input logic store);
        return (f3[1:0] == 2'b11) || (f3 == 3'b110) || (store && f3[2]);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Byte-wide RAM port between the load/store engine (master) and the memory (slave).
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wr_o;
    logic [7:0]        mem_dout_o;
    logic [7:0]        mem_din_i;

    modport master (
        output mem_addr_o,
        output mem_wr_o,
        output mem_dout_o,
        input  mem_din_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_wr_o,
        input  mem_dout_o,
        output mem_din_i
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of an assembled, right-aligned load value by funct3.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ext_o
);
    always_comb begin
        case (funct3_i)
            F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_BU:   ext_o = {24'h000000, raw_i[7:0]};
            F3_HU:   ext_o = {16'h0000, raw_i[15:0]};
            F3_W:    ext_o = raw_i;
            default: ext_o = raw_i;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: byte-serial RAM accesses, sign/zero-extended load
// write-back and ALU result pass-through, with a pipeline stall while busy.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   sdata_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [XLEN-1:0]   wdata_i,
    mem_access_unit_if.master mem,
    output logic              stall_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [XLEN-1:0]   wdata_o
);
    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        n_q, n_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        req_wd_q, req_wd_d;
    logic              req_wreg_q, req_wreg_d;
    logic [XLEN-1:0]   shift_q, shift_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    logic              mem_go;
    logic [XLEN-1:0]   asm_full;
    logic [XLEN-1:0]   load_raw;
    logic [XLEN-1:0]   load_ext;

    assign mem_go  = (is_load_i | is_store_i) & ~f3_reserved(funct3_i, is_store_i);
    assign stall_o = (state_q != ST_IDLE) | (req_valid_i & mem_go);

    // Load bytes enter at the top; after N captures they occupy the upper N bytes.
    assign asm_full = {mem.mem_din_i, shift_q[XLEN-1:8]};

    always_comb begin
        case (n_q)
            3'd1:    load_raw = {24'h000000, asm_full[31:24]};
            3'd2:    load_raw = {16'h0000, asm_full[31:16]};
            default: load_raw = asm_full;
        endcase
    end

    mem_access_unit_load_extend u_load_extend (
        .raw_i    (load_raw),
        .funct3_i (funct3_q),
        .ext_o    (load_ext)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        n_d        = n_q;
        is_load_d  = is_load_q;
        funct3_d   = funct3_q;
        req_wd_d   = req_wd_q;
        req_wreg_d = req_wreg_q;
        shift_d    = shift_q;
        mem_addr_d = mem_addr_q;
        mem_wr_d   = 1'b0;
        mem_dout_d = mem_dout_q;
        wd_d       = wd_q;
        wreg_d     = 1'b0;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (mem_go) begin
                        state_d    = ST_ISSUE;
                        k_d        = 3'd1;
                        n_d        = access_bytes(funct3_i);
                        is_load_d  = is_load_i;
                        funct3_d   = funct3_i;
                        req_wd_d   = wd_i;
                        req_wreg_d = wreg_i;
                        mem_addr_d = ADDR_W'(addr_i);
                        if (is_store_i) begin
                            mem_wr_d   = 1'b1;
                            mem_dout_d = sdata_i[7:0];
                            shift_d    = {8'h00, sdata_i[XLEN-1:8]};
                        end
                    end else begin
                        // ALU pass-through, or a reserved access that retires silently
                        wd_d    = wd_i;
                        wdata_d = wdata_i;
                        wreg_d  = wreg_i & ~(is_load_i | is_store_i);
                    end
                end
            end
            ST_ISSUE: begin
                if (k_q < n_q) begin
                    k_d        = k_q + 3'd1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    if (!is_load_q) begin
                        mem_wr_d   = 1'b1;
                        mem_dout_d = shift_q[7:0];
                        shift_d    = {8'h00, shift_q[XLEN-1:8]};
                    end
                end else begin
                    state_d = is_load_q ? ST_DRAIN : ST_IDLE;
                end
                // Read data trails its address by one cycle, so capture starts at k=2.
                if (is_load_q && (k_q >= 3'd2)) begin
                    shift_d = asm_full;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                wd_d    = req_wd_q;
                wreg_d  = req_wreg_q;
                wdata_d = load_ext;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= 8'h00;
            wd_q       <= 5'd0;
            wreg_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
        k_q        <= k_d;
        n_q        <= n_d;
        is_load_q  <= is_load_d;
        funct3_q   <= funct3_d;
        req_wd_q   <= req_wd_d;
        req_wreg_q <= req_wreg_d;
        shift_q    <= shift_d;
    end

    assign mem.mem_addr_o = mem_addr_q;
    assign mem.mem_wr_o   = mem_wr_q;
    assign mem.mem_dout_o = mem_dout_q;
    assign wd_o           = wd_q;
    assign wreg_o         = wreg_q;
    assign wdata_o        = wdata_q;
endmodule
